// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the picorv32 native bus: DATA/STATUS/DIV registers and a TX FIFO.
// Optional completion interrupt (irq port, STATUS bit3) is built when MMIO_UART_TX_IRQ_EN is defined.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
`ifdef MMIO_UART_TX_IRQ_EN
   output logic        irq,
`endif
   output logic        txd
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [15:0]   div_q, div_d, period_q, period_d, cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q, txd_d, ready_q, ready_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [7:0]    fifo_mem [FIFO_DEPTH];

   logic          claim, push_req, accept, push, pop, full, empty, bit_end;
   logic [1:0]    offset;
   logic [31:0]   rd_val;
   logic          unused_bits;

`ifdef MMIO_UART_TX_IRQ_EN
   logic          irq_q, irq_d;
`endif

   assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

   // Bus decode, FIFO bookkeeping, register file and serialiser next state.
   always_comb begin
      full     = (level_q == LW'(FIFO_DEPTH));
      empty    = (level_q == '0);
      offset   = mem_addr[3:2];
      claim    = mem_valid && !ready_q && (mem_addr[31:4] == BASE_ADDR[31:4]);
      bit_end  = (cnt_q == period_q - 16'd1);
      pop      = (state_q == S_IDLE) && !empty;
      push_req = claim && (offset == 2'd0) && mem_wstrb[0];
      // A push into a full FIFO is only taken when the serialiser frees a slot this cycle.
      accept   = claim && !(push_req && full && !pop);
      push     = push_req && accept;

      rd_val = '0;
      case (offset)
         2'd1: begin
            rd_val[0]       = (state_q != S_IDLE);
            rd_val[1]       = full;
            rd_val[2]       = empty;
`ifdef MMIO_UART_TX_IRQ_EN
            rd_val[3]       = irq_q;
`endif
            rd_val[8 +: LW] = level_q;
         end
         2'd2:    rd_val[15:0] = div_q;
         default: rd_val = '0;
      endcase

      ready_d = accept;
      rdata_d = accept ? rd_val : rdata_q;

      div_d = div_q;
      if (accept && (offset == 2'd2)) begin
         if (mem_wstrb[0]) div_d[7:0]  = mem_wdata[7:0];
         if (mem_wstrb[1]) div_d[15:8] = mem_wdata[15:8];
      end

      wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      period_d = period_q;
      txd_d    = txd_q;
      rptr_d   = rptr_q;
      case (state_q)
         S_IDLE: begin
            txd_d = 1'b1;
            if (pop) begin
               shift_d  = fifo_mem[rptr_q];
               rptr_d   = rptr_q + AW'(1);
               period_d = (div_q == 16'd0) ? 16'd1 : div_q;
               cnt_d    = '0;
               bit_d    = '0;
               state_d  = S_START;
               txd_d    = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = S_DATA;
               txd_d   = shift_q[0];
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  txd_d   = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               txd_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef MMIO_UART_TX_IRQ_EN
      // Clear on a STATUS write of bit0; a simultaneous completion wins.
      irq_d = irq_q;
      if (accept && (offset == 2'd1) && mem_wstrb[0] && mem_wdata[0]) irq_d = 1'b0;
      if ((state_q == S_STOP) && bit_end && (level_d == '0)) irq_d = 1'b1;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         wptr_q   <= '0;
         rptr_q   <= '0;
         level_q  <= '0;
         div_q    <= DEFAULT_DIV;
         period_q <= 16'd1;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         txd_q    <= 1'b1;
         ready_q  <= 1'b0;
         rdata_q  <= '0;
`ifdef MMIO_UART_TX_IRQ_EN
         irq_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         level_q  <= level_d;
         div_q    <= div_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         txd_q    <= txd_d;
         ready_q  <= ready_d;
         rdata_q  <= rdata_d;
`ifdef MMIO_UART_TX_IRQ_EN
         irq_q    <= irq_d;
`endif
      end
   end

   // FIFO storage needs no reset: entries are only read behind the write pointer.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr_q] <= mem_wdata[7:0];
   end

   assign mem_ready = ready_q;
   assign mem_rdata = rdata_q;
   assign txd       = txd_q;
`ifdef MMIO_UART_TX_IRQ_EN
   assign irq       = irq_q;
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed bus steps plus random byte streams,
// with txd compared against frames computed from the 8N1 rules.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int MAXC = 20000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_valid, mem_ready, txd;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
`ifdef MMIO_UART_TX_IRQ_EN
   logic        irq;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int edge_n   = 0;
   bit hist_txd [MAXC];
   bit hist_irq [MAXC];

   logic [31:0] last_rd;
   int          last_lat;
   bit          last_got;

   mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd868)) dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
`ifdef MMIO_UART_TX_IRQ_EN
      .irq(irq),
`endif
      .txd(txd)
   );

   always #5 clk = ~clk;

   // hist_*[k] holds the value during the cycle following rising edge k.
   always @(posedge clk) edge_n <= edge_n + 1;
   always @(negedge clk) begin
      if (edge_n < MAXC) begin
         hist_txd[edge_n] <= txd;
`ifdef MMIO_UART_TX_IRQ_EN
         hist_irq[edge_n] <= irq;
`else
         hist_irq[edge_n] <= 1'b0;
`endif
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int target);
      for (int g = 0; g < 20000 && edge_n < target; g++) tick(1);
   endtask

   // One bus request, held until acknowledged or the budget runs out.
   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int budget);
      if (mem_ready) tick(1);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = d;
      mem_wstrb = s;
      last_rd = '0;
      last_lat = 0;
      last_got = 1'b0;
      for (int i = 1; i <= budget && !last_got; i++) begin
         @(posedge clk);
         #1;
         if (mem_ready) begin
            last_got = 1'b1;
            last_lat = i;
            last_rd  = mem_rdata;
         end
      end
      mem_valid = 1'b0;
      mem_wstrb = '0;
   endtask

   function automatic int find_fall(input int from, input int upto);
      for (int k = from + 1; k <= upto && k < MAXC; k++)
         if (hist_txd[k] == 1'b0 && hist_txd[k-1] == 1'b1) return k;
      return -1;
   endfunction

   // Reference 8N1 frame: start 0, data LSB first, stop 1, each slot p clocks.
   function automatic bit frame_bit(input logic [7:0] b, input int j, input int p);
      int slot;
      slot = j / p;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return b[slot-1];
   endfunction

   task automatic check_frame(input string tag, input int base, input logic [7:0] b, input int p);
      int mism;
      mism = 0;
      if (base < 1 || base + 10 * p >= MAXC) mism = 1;
      else begin
         for (int j = 0; j < 10 * p; j++)
            if (hist_txd[base + j] !== frame_bit(b, j, p)) mism++;
         if (hist_txd[base + 10 * p] !== 1'b1) mism++;
      end
      check(tag, 32'(mism), 32'd0);
   endtask

   initial begin
      int e0, fall, s0, bad, rel;
      int acks[10];
      int lats[10];
      logic [7:0] q[$];

      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;

      // Asynchronous reset values before any clock edge.
      #1 reset = 1'b1;
      #1;
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_ready", 32'(mem_ready), 32'd0);
      check("rst_rdata", mem_rdata, 32'd0);
      tick(3);
      reset = 1'b0;
      tick(1);

      // Reset register contents and single-cycle read latency.
      bus(BASE + 32'd4, 32'd0, 4'b0000, 8);
      check("t1_stat_lat", 32'(last_lat), 32'd1);
      check("t1_status", last_rd, 32'h0000_0004);
      check("t1_txd", 32'(txd), 32'd1);
      bus(BASE + 32'd8, 32'd0, 4'b0000, 8);
      check("t1_div", last_rd, 32'd868);

      // A5 at DIV=4, 3C queued behind it, DIV changed to 2 mid-frame.
      bus(BASE + 32'd8, 32'd4, 4'b0011, 8);
      check("t2_div_wlat", 32'(last_lat), 32'd1);
      bus(BASE, 32'h0000_00A5, 4'b0001, 8);
      check("t2_data_wlat", 32'(last_lat), 32'd1);
      e0 = edge_n;
      bus(BASE, 32'h0000_003C, 4'b0001, 8);
      bus(BASE + 32'd8, 32'd2, 4'b0011, 8);
      tick(6);
      bus(BASE + 32'd4, 32'd0, 4'b0000, 8);
      check("t2_status_busy", last_rd, 32'h0000_0101);
      wait_until(e0 + 1 + 41 + 21 + 3);
      fall = find_fall(e0, edge_n - 1);
      check("t2_first_fall", 32'(fall), 32'(e0 + 1));
      check_frame("t2_frame_a5", fall, 8'hA5, 4);
      check_frame("t2_frame_3c", fall + 41, 8'h3C, 2);
      bus(BASE + 32'd4, 32'd0, 4'b0000, 8);
      check("t2_status_idle", last_rd, 32'h0000_0004);

      // DIV byte strobes, reserved offset, DATA write without byte 0, out-of-window accesses.
      s0 = edge_n;
      bus(BASE + 32'd8, 32'h0000_AB77, 4'b0010, 8);
      bus(BASE + 32'd8, 32'd0, 4'b0000, 8);
      check("t3_div_strobe", last_rd, 32'h0000_AB02);
      bus(BASE + 32'd12, 32'hFFFF_FFFF, 4'b1111, 8);
      bus(BASE + 32'd12, 32'd0, 4'b0000, 8);
      check("t3_reserved", last_rd, 32'd0);
      bus(BASE, 32'h0000_5500, 4'b0010, 8);
      check("t3_nostrobe_ack", 32'(last_got), 32'd1);
      bus(BASE + 32'd16, 32'h0000_0055, 4'b0001, 6);
      check("t3_base16_noack", 32'(last_got), 32'd0);
      bus(32'h0000_0100, 32'h0000_0055, 4'b0001, 6);
      check("t3_low_noack", 32'(last_got), 32'd0);
      bus(BASE + 32'd16, 32'd0, 4'b0000, 6);
      check("t3_rd16_noack", 32'(last_got), 32'd0);
      bus(BASE + 32'd4, 32'd0, 4'b0000, 8);
      check("t3_status", last_rd, 32'h0000_0004);
      tick(10);
      check("t3_no_frame", 32'(find_fall(s0, edge_n - 1)), 32'hFFFF_FFFF);
      bus(BASE + 32'd8, 32'd2, 4'b0011, 8);

      // Ten pushes at DIV=2: the tenth stalls until the second frame's pop frees a slot.
      for (int i = 0; i < 10; i++) begin
         bus(BASE, 32'(i), 4'b0001, 64);
         acks[i] = edge_n;
         lats[i] = last_lat;
      end
      bad = 0;
      for (int i = 0; i < 9; i++) if (lats[i] != 1) bad++;
      check("t4_lat_unstalled", 32'(bad), 32'd0);
      bus(BASE + 32'd4, 32'd0, 4'b0000, 8);
      check("t4_status_full", last_rd, 32'h0000_0803);
      wait_until(acks[0] + 1 + 10 * 21 + 3);
      fall = find_fall(acks[0], edge_n - 1);
      check("t4_first_fall", 32'(fall), 32'(acks[0] + 1));
      check("t4_stall_release", 32'(acks[9]), 32'(fall + 21));
      for (int i = 0; i < 10; i++)
         check_frame($sformatf("t4_frame%0d", i), fall + i * 21, 8'(i), 2);

      // Random byte streams at random DIV (first round DIV=0).
      for (int r = 0; r < 3; r++) begin
         int dv, p, n;
         logic [7:0] b;
         dv = (r == 0) ? 0 : int'($urandom_range(1, 5));
         n  = int'($urandom_range(1, 6));
         p  = (dv == 0) ? 1 : dv;
         bus(BASE + 32'd8, 32'(dv), 4'b0011, 8);
         q.delete();
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            bus(BASE, {24'h0, b}, 4'b0001, 64);
            if (i == 0) e0 = edge_n;
         end
         wait_until(e0 + 1 + n * (10 * p + 1) + 3);
         fall = find_fall(e0, edge_n - 1);
         check($sformatf("rnd%0d_fall", r), 32'(fall), 32'(e0 + 1));
         for (int i = 0; i < n; i++)
            check_frame($sformatf("rnd%0d_frame%0d", r, i), fall + i * (10 * p + 1), q[i], p);
         bus(BASE + 32'd4, 32'd0, 4'b0000, 8);
         check($sformatf("rnd%0d_status", r), last_rd, 32'h0000_0004);
      end

      // Reset during a data bit with three bytes still queued.
      bus(BASE + 32'd8, 32'd8, 4'b0011, 8);
      for (int i = 0; i < 4; i++) begin
         bus(BASE, 32'd0, 4'b0001, 64);
         if (i == 0) e0 = edge_n;
      end
      tick(3);
      fall = find_fall(e0, edge_n - 1);
      wait_until(fall + 27);
      check("t7_pre_txd", 32'(txd), 32'd0);
      #2 reset = 1'b1;
      #1;
      check("t7_async_txd", 32'(txd), 32'd1);
      check("t7_async_ready", 32'(mem_ready), 32'd0);
      tick(2);
      reset = 1'b0;
      rel = edge_n;
      bus(BASE + 32'd4, 32'd0, 4'b0000, 8);
      check("t7_status", last_rd, 32'h0000_0004);
      bus(BASE + 32'd8, 32'd0, 4'b0000, 8);
      check("t7_div", last_rd, 32'd868);
      tick(100);
      check("t7_no_frame", 32'(find_fall(rel, edge_n - 1)), 32'hFFFF_FFFF);

`ifdef MMIO_UART_TX_IRQ_EN
      // Completion interrupt after the last of two queued bytes, cleared by STATUS write.
      bus(BASE + 32'd8, 32'd1, 4'b0011, 8);
      bus(BASE, 32'h0000_0081, 4'b0001, 8);
      e0 = edge_n;
      bus(BASE, 32'h0000_007E, 4'b0001, 8);
      wait_until(e0 + 35);
      fall = find_fall(e0, edge_n - 1);
      check_frame("t8_frame0", fall, 8'h81, 1);
      check_frame("t8_frame1", fall + 11, 8'h7E, 1);
      check("t8_irq_before", 32'(hist_irq[fall + 20]), 32'd0);
      check("t8_irq_rise", 32'(hist_irq[fall + 21]), 32'd1);
      bad = 0;
      for (int k = e0 + 1; k < edge_n; k++) if (hist_irq[k] && !hist_irq[k-1]) bad++;
      check("t8_irq_rise_count", 32'(bad), 32'd1);
      bus(BASE + 32'd4, 32'd0, 4'b0000, 8);
      check("t8_status_irq", last_rd, 32'h0000_000C);
      bus(BASE + 32'd4, 32'd1, 4'b0001, 8);
      check("t8_irq_clear", 32'(irq), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
